// File: rtl/simple_adder_pkg.sv
// Shared definitions for the serial chunk adder: FSM state encoding and
// default operand / chunk widths.
package simple_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

endpackage

// File: rtl/serial_chunk_adder_carry_chunk.sv
// carry_chunk: one combinational CHUNK-bit generate/propagate ripple adder.
// g_top is the generate term of the most significant bit of the chunk and is
// used as the approximate inter-chunk carry when that mode is built in.
module carry_chunk
  import simple_adder_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] s,
  output logic             c_out,
  output logic             g_top
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;

  // Ripple the carry bit by bit through the chunk using G/P terms.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    s    = '0;
    c[0] = c_in;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s[i]   = p[i] ^ c[i];
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign c_out = c[CHUNK];
  assign g_top = g[CHUNK-1];

endmodule

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: adds two WIDTH-bit operands CHUNK bits per cycle with a
// valid/ready handshake on both sides (IDLE -> RUN -> DONE).
// Build option: define SERIAL_CHUNK_ADDER_APPROX_CARRY_EN to pass only the
// top-bit generate term between chunks (approximate carry); the default build
// uses the exact ripple carry. Handshake timing is the same in both builds.
module serial_chunk_adder
  import simple_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_q;
  logic [KW-1:0]    k;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK-1:0] s_ch;
  logic             c_out;
  logic             g_top;
  logic             c_next;

  // Select chunk k of both registered operands.
  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (k == KW'(i)) begin
        a_ch = a_q[i*CHUNK +: CHUNK];
        b_ch = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  carry_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_ch),
    .b     (b_ch),
    .c_in  (c_q),
    .s     (s_ch),
    .c_out (c_out),
    .g_top (g_top)
  );

`ifdef SERIAL_CHUNK_ADDER_APPROX_CARRY_EN
  logic unused_cout;
  assign unused_cout = c_out;
  assign c_next      = g_top;
`else
  logic unused_gtop;
  assign unused_gtop = g_top;
  assign c_next      = c_out;
`endif

  // Handshake FSM with operand, sum, carry and chunk-index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      c_q         <= 1'b0;
      k           <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q        <= in1;
            b_q        <= in2;
            c_q        <= cin;
            k          <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (k == KW'(i)) begin
              sum_q[i*CHUNK +: CHUNK] <= s_ch;
            end
          end
          c_q <= c_next;
          if (k == KW'(NCHUNK - 1)) begin
            k           <= '0;
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry     = c_q;

endmodule
